// File: rtl/gg_add_seq.sv
// Multi-cycle add/subtract unit that processes SLICE bits per clock.
// S, CO and OVF are updated only on the edge that finishes the last slice.
`timescale 1ns/1ps
module gg_add_seq #(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             CK,
    input  logic             CLR,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OVF,
    output logic [1:0]       DBG_STATE
);

    if (SLICE < 1) begin : g_bad_slice
        $fatal(1, "gg_add_seq: SLICE must be at least 1");
    end else if (WIDTH % SLICE != 0) begin : g_bad_width
        $fatal(1, "gg_add_seq: WIDTH must be a multiple of SLICE");
    end

    localparam int N  = (SLICE >= 1) ? WIDTH / SLICE : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      base;
    logic [SLICE-1:0] a_sl, b_sl;
    logic [SLICE:0]   sum;

    always_ff @(posedge CK or negedge CLR) begin
        if (!CLR) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    // Subtraction is A + ~B + (1 - CI), so B is stored already inverted.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        base = 32'(cnt_q) * 32'(SLICE);
        a_sl = a_q[base +: SLICE];
        b_sl = b_q[base +: SLICE];
        sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};

        case (state_q)
            IDLE, FIN: begin
                if (START) begin
                    a_d     = A;
                    b_d     = SUB ? ~B : B;
                    carry_d = CI ^ SUB;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d[base +: SLICE] = sum[SLICE-1:0];
                carry_d = sum[SLICE];
                if (cnt_q == LAST) begin
                    s_d     = res_d;
                    co_d    = sum[SLICE];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (res_d[WIDTH-1] != a_q[WIDTH-1]);
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign BUSY      = (state_q == RUN);
    assign DONE      = (state_q == FIN);
    assign S         = s_q;
    assign CO        = co_q;
    assign OVF       = ovf_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_gg_add_seq.sv
// Directed bench for gg_add_seq: 8-bit/2-bit-slice instance plus two 4-bit
// instances (SLICE=1 and SLICE=4) swept exhaustively against a signed reference.
`timescale 1ns/1ps
module tb_gg_add_seq;

  logic ck = 1'b0;
  logic clr = 1'b0;

  logic       start = 1'b0, sub = 1'b0, ci = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, co, ovf;
  logic [7:0] s;
  logic [1:0] dbg;

  logic       start4 = 1'b0, sub4 = 1'b0, ci4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy1, done1, co1, ovf1, busy4, done4, co4, ovf4;
  logic [3:0] s1, s4;
  logic [1:0] dbg1, dbg4;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [7:0] a, b;
    logic       ci, sub;
    logic [7:0] s;
    logic       co, ovf;
  } vec_t;

  // Expected values worked out by hand.
  vec_t vecs [0:9] = '{
    '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
    '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0},
    '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1},
    '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1},
    '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1},
    '{8'h10, 8'h05, 1'b1, 1'b1, 8'h0A, 1'b1, 1'b0},
    '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1},
    '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0},
    '{8'h3C, 8'hA5, 1'b1, 1'b0, 8'hE2, 1'b0, 1'b0},
    '{8'h12, 8'h12, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0}
  };

  gg_add_seq #(.WIDTH(8), .SLICE(2)) dut (
    .CK(ck), .CLR(clr), .START(start), .SUB(sub), .A(a), .B(b), .CI(ci),
    .BUSY(busy), .DONE(done), .S(s), .CO(co), .OVF(ovf), .DBG_STATE(dbg)
  );

  gg_add_seq #(.WIDTH(4), .SLICE(1)) dut_s1 (
    .CK(ck), .CLR(clr), .START(start4), .SUB(sub4), .A(a4), .B(b4), .CI(ci4),
    .BUSY(busy1), .DONE(done1), .S(s1), .CO(co1), .OVF(ovf1), .DBG_STATE(dbg1)
  );

  gg_add_seq #(.WIDTH(4), .SLICE(4)) dut_s4 (
    .CK(ck), .CLR(clr), .START(start4), .SUB(sub4), .A(a4), .B(b4), .CI(ci4),
    .BUSY(busy4), .DONE(done4), .S(s4), .CO(co4), .OVF(ovf4), .DBG_STATE(dbg4)
  );

  // ---------------- clock / watchdog ----------------
  always #5 ck = ~ck;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [5:0] ref4(input logic [3:0] x, input logic [3:0] y,
                                      input logic c, input logic sb);
    int sx, sy, r;
    logic [4:0] u;
    logic [3:0] rs;
    logic rco;
    sx = x[3] ? int'(x) - 16 : int'(x);
    sy = y[3] ? int'(y) - 16 : int'(y);
    if (!sb) begin
      u   = {1'b0, x} + {1'b0, y} + {4'b0, c};
      rs  = u[3:0];
      rco = u[4];
      r   = sx + sy + int'(c);
    end else begin
      rs  = x - y - {3'b0, c};
      rco = (int'(x) >= int'(y) + int'(c));
      r   = sx - sy - int'(c);
    end
    return {rs, rco, (r > 7) || (r < -8)};
  endfunction

  // ---------------- driver ----------------
  // Called just after a negedge; returns at the negedge where DONE is seen.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tci,
                        input logic tsub, output logic [7:0] rs, output logic rco,
                        output logic rovf, output int lat, output int busy_n,
                        output logic [7:0] s_run);
    a = ta; b = tb; ci = tci; sub = tsub; start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    lat = 1;
    busy_n = 0;
    s_run = s;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      @(negedge ck);
      lat++;
    end
    rs = s; rco = co; rovf = ovf;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr = 1'b0;
    repeat (2) @(negedge ck);
    tests_run++;
    if ({busy, done, s, co, ovf, dbg} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_held: busy=%b done=%b s=%h co=%b ovf=%b st=%0d, required all zero",
               busy, done, s, co, ovf, dbg);
    end
    clr = 1'b1;
    @(negedge ck);
    tests_run++;
    if ({busy, done, s, co, ovf, dbg} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_release: busy=%b done=%b s=%h co=%b ovf=%b st=%0d, required all zero",
               busy, done, s, co, ovf, dbg);
    end
  endtask

  task automatic test_arith();
    logic [7:0] rs, srun;
    logic rco, rovf;
    int lat, bn;
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, rs, rco, rovf, lat, bn, srun);
      tests_run++;
      if ({rs, rco, rovf} !== {vecs[i].s, vecs[i].co, vecs[i].ovf}) begin
        tests_failed++;
        $display("FAIL arith[%0d] %h %s %h ci=%b: got s=%h co=%b ovf=%b, required s=%h co=%b ovf=%b",
                 i, vecs[i].a, vecs[i].sub ? "-" : "+", vecs[i].b, vecs[i].ci,
                 rs, rco, rovf, vecs[i].s, vecs[i].co, vecs[i].ovf);
      end
      tests_run++;
      if (lat !== 5 || bn !== 4) begin
        tests_failed++;
        $display("FAIL timing[%0d]: done after %0d edges busy %0d cycles, required 5 and 4", i, lat, bn);
      end
      @(negedge ck);
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0 || s !== vecs[i].s) begin
        tests_failed++;
        $display("FAIL fin_to_idle[%0d]: done=%b busy=%b s=%h, required 0 0 %h", i, done, busy, s, vecs[i].s);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat, bn;
    a = 8'h11; b = 8'h22; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    lat = 1;
    bn = 0;
    while (!done && lat < 20) begin
      if (busy) bn++;
      if (lat == 1 || lat == 2) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF;
      end else begin
        start = 1'b0;
      end
      @(negedge ck);
      lat++;
    end
    start = 1'b0;
    tests_run++;
    if (s !== 8'h33 || co !== 1'b0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_ignored_result: s=%h co=%b ovf=%b, required 33 0 0", s, co, ovf);
    end
    tests_run++;
    if (lat !== 5 || bn !== 4) begin
      tests_failed++;
      $display("FAIL start_ignored_timing: done after %0d busy %0d, required 5 and 4", lat, bn);
    end
    @(negedge ck);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_ignored_restart: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] rs, srun;
    logic rco, rovf, done_seen;
    int lat, bn;
    a = 8'h55; b = 8'h0A; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    @(negedge ck);
    @(posedge ck);
    #2 clr = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, s, co, ovf, dbg} !== 13'd0) begin
      tests_failed++;
      $display("FAIL abort_clear: busy=%b done=%b s=%h co=%b ovf=%b st=%0d, required all zero",
               busy, done, s, co, ovf, dbg);
    end
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge ck);
      if (done) done_seen = 1'b1;
    end
    clr = 1'b1;
    repeat (5) begin
      @(negedge ck);
      if (done) done_seen = 1'b1;
    end
    tests_run++;
    if (done_seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_done: done_seen=%b, required 0", done_seen);
    end
    run_op(8'h03, 8'h04, 1'b0, 1'b0, rs, rco, rovf, lat, bn, srun);
    tests_run++;
    if (rs !== 8'h07 || rco !== 1'b0 || lat !== 5) begin
      tests_failed++;
      $display("FAIL after_abort: s=%h co=%b lat=%0d, required 07 0 5", rs, rco, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rs, srun;
    logic rco, rovf;
    int lat, bn;
    run_op(8'h20, 8'h30, 1'b0, 1'b0, rs, rco, rovf, lat, bn, srun);
    tests_run++;
    if (rs !== 8'h50 || rco !== 1'b0 || rovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_first: s=%h co=%b ovf=%b, required 50 0 0", rs, rco, rovf);
    end
    run_op(8'h09, 8'h04, 1'b0, 1'b1, rs, rco, rovf, lat, bn, srun);
    tests_run++;
    if (srun !== 8'h50) begin
      tests_failed++;
      $display("FAIL b2b_hold: s during second run=%h, required 50", srun);
    end
    tests_run++;
    if (rs !== 8'h05 || rco !== 1'b1 || rovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second: s=%h co=%b ovf=%b, required 05 1 0", rs, rco, rovf);
    end
    tests_run++;
    if (lat !== 5 || bn !== 4) begin
      tests_failed++;
      $display("FAIL b2b_timing: done after %0d busy %0d, required 5 and 4", lat, bn);
    end
    @(negedge ck);
  endtask

  task automatic test_exhaustive4();
    logic [5:0] exp_r, r1, r4;
    int lat, lat1, lat4;
    for (int sb = 0; sb < 2; sb++) begin
      for (int c = 0; c < 2; c++) begin
        for (int x = 0; x < 16; x++) begin
          for (int y = 0; y < 16; y++) begin
            a4 = 4'(x); b4 = 4'(y); ci4 = 1'(c); sub4 = 1'(sb); start4 = 1'b1;
            exp_r = ref4(4'(x), 4'(y), 1'(c), 1'(sb));
            @(negedge ck);
            start4 = 1'b0;
            lat = 1; lat1 = 0; lat4 = 0; r1 = '0; r4 = '0;
            while (lat < 12) begin
              if (done1 && lat1 == 0) begin lat1 = lat; r1 = {s1, co1, ovf1}; end
              if (done4 && lat4 == 0) begin lat4 = lat; r4 = {s4, co4, ovf4}; end
              if (lat1 != 0 && lat4 != 0) break;
              @(negedge ck);
              lat++;
            end
            tests_run++;
            if (r1 !== exp_r || lat1 !== 5) begin
              tests_failed++;
              $display("FAIL sweep_s1 a=%h b=%h ci=%0d sub=%0d: got {s,co,ovf}=%b lat=%0d, required %b lat=5",
                       x, y, c, sb, r1, lat1, exp_r);
            end
            tests_run++;
            if (r4 !== exp_r || lat4 !== 2) begin
              tests_failed++;
              $display("FAIL sweep_s4 a=%h b=%h ci=%0d sub=%0d: got {s,co,ovf}=%b lat=%0d, required %b lat=2",
                       x, y, c, sb, r4, lat4, exp_r);
            end
          end
        end
      end
    end
    @(negedge ck);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_arith();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_exhaustive4();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
